// File: rtl/acc32_pkg.sv
// Shared types and constants for the acc32_stream accumulator.
// Imported by the interface, the adder wrapper and the top.
package acc32_pkg;

  localparam int DATA_W = 32;
  localparam int BEAT_W = 16;
  localparam logic [DATA_W-1:0] SAT_VALUE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/acc32_stream_if.sv
// Operand stream in, packet result out.
// master drives operands and result-ready; slave is the accumulator.
interface acc32_stream_if;
  import acc32_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_carry;
  logic              out_trunc;
  logic [BEAT_W-1:0] out_beats;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_carry, out_trunc, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum,
    output out_carry, out_trunc, out_beats
  );

endinterface

// File: rtl/acc32_stream_adder.sv
// carryselect_adder: 32-bit carry-select adder built from 8-bit blocks.
// Each block precomputes both carry-in cases and selects on the ripple carry.
module carryselect_adder #(
  parameter int W = 32,
  parameter int B = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int N = W / B;

  logic [N:0] c;

  assign c[0] = cin;
  assign cout = c[N];

  for (genvar g = 0; g < N; g++) begin : g_blk
    logic [B:0] s0;
    logic [B:0] s1;

    assign s0 = {1'b0, a[g*B +: B]}
              + {1'b0, b[g*B +: B]};
    assign s1 = {1'b0, a[g*B +: B]}
              + {1'b0, b[g*B +: B]}
              + {{B{1'b0}}, 1'b1};

    assign sum[g*B +: B] = c[g] ? s1[B-1:0]
                                : s0[B-1:0];
    assign c[g+1] = c[g] ? s1[B] : s0[B];
  end

endmodule

// File: rtl/acc32_stream.sv
// Packet accumulator: sums a beat stream into one result per packet.
// Define ACC32_STREAM_SAT_EN to saturate the sum instead of wrapping.
module acc32_stream
  import acc32_pkg::*;
#(
  parameter int MAX_BEATS = 256
) (
  input logic           clk,
  input logic           rst,
  acc32_stream_if.slave bus
);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic              carry;
  logic              trunc;
  logic [BEAT_W-1:0] beats;
  logic              ready_q;
  logic              valid_q;

  logic [DATA_W-1:0] sum_w;
  logic              cout_w;
  logic [DATA_W-1:0] acc_add;
  logic [BEAT_W-1:0] beats_inc;
  logic              take;
  logic              at_max;
  logic              one_max;
  logic              go_idle;
  logic              go_acc;

  carryselect_adder #(
    .W (DATA_W),
    .B (8)
  ) u_add (
    .a    (acc),
    .b    (bus.in_data),
    .cin  (1'b0),
    .sum  (sum_w),
    .cout (cout_w)
  );

`ifdef ACC32_STREAM_SAT_EN
  // Once saturated, any non-zero add carries again and reloads SAT_VALUE.
  assign acc_add = cout_w ? SAT_VALUE : sum_w;
`else
  assign acc_add = sum_w;
`endif

  assign take      = bus.in_valid && ready_q;
  assign beats_inc = beats + 1'b1;
  assign at_max    = beats_inc == BEAT_W'(MAX_BEATS);
  assign one_max   = MAX_BEATS == 1;
  assign go_idle   = bus.in_last || one_max;
  assign go_acc    = bus.in_last || at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      carry   <= 1'b0;
      trunc   <= 1'b0;
      beats   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            acc     <= bus.in_data;
            carry   <= 1'b0;
            beats   <= BEAT_W'(1);
            trunc   <= one_max && !bus.in_last;
            state   <= go_idle ? HOLD : ACCUM;
            ready_q <= !go_idle;
            valid_q <= go_idle;
          end
        end
        ACCUM: begin
          if (take) begin
            acc     <= acc_add;
            carry   <= carry | cout_w;
            beats   <= beats_inc;
            trunc   <= at_max && !bus.in_last;
            state   <= go_acc ? HOLD : ACCUM;
            ready_q <= !go_acc;
            valid_q <= go_acc;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = acc;
  assign bus.out_carry = carry;
  assign bus.out_trunc = trunc;
  assign bus.out_beats = beats;

endmodule

// File: tb/tb_acc32_stream.sv
// Directed-vector and scoreboard bench for acc32_stream.
// Three instances share stimulus: MAX_BEATS 256, 4 and 1.
module tb_acc32_stream;
  import acc32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  int          sel = 0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  acc32_stream_if ia ();
  acc32_stream_if ib ();
  acc32_stream_if ic ();

  assign ia.in_valid  = in_valid;
  assign ia.in_data   = in_data;
  assign ia.in_last   = in_last;
  assign ia.out_ready = out_ready;
  assign ib.in_valid  = in_valid;
  assign ib.in_data   = in_data;
  assign ib.in_last   = in_last;
  assign ib.out_ready = out_ready;
  assign ic.in_valid  = in_valid;
  assign ic.in_data   = in_data;
  assign ic.in_last   = in_last;
  assign ic.out_ready = out_ready;

  acc32_stream #(.MAX_BEATS(256)) u_a (
    .clk (clk), .rst (rst), .bus (ia.slave)
  );
  acc32_stream #(.MAX_BEATS(4)) u_b (
    .clk (clk), .rst (rst), .bus (ib.slave)
  );
  acc32_stream #(.MAX_BEATS(1)) u_c (
    .clk (clk), .rst (rst), .bus (ic.slave)
  );

  logic        rdy;
  logic        ovalid;
  logic [31:0] osum;
  logic        ocarry;
  logic        otrunc;
  logic [15:0] obeats;

  always_comb begin
    rdy    = ia.in_ready;
    ovalid = ia.out_valid;
    osum   = ia.out_sum;
    ocarry = ia.out_carry;
    otrunc = ia.out_trunc;
    obeats = ia.out_beats;
    if (sel == 1) begin
      rdy    = ib.in_ready;
      ovalid = ib.out_valid;
      osum   = ib.out_sum;
      ocarry = ib.out_carry;
      otrunc = ib.out_trunc;
      obeats = ib.out_beats;
    end else if (sel == 2) begin
      rdy    = ic.in_ready;
      ovalid = ic.out_valid;
      osum   = ic.out_sum;
      ocarry = ic.out_carry;
      otrunc = ic.out_trunc;
      obeats = ic.out_beats;
    end
  end

`ifdef ACC32_STREAM_SAT_EN
  localparam bit SAT = 1'b1;
  localparam logic [31:0] E_WRAP = 32'hFFFF_FFFF;
`else
  localparam bit SAT = 1'b0;
  localparam logic [31:0] E_WRAP = 32'd1;
`endif

  typedef struct packed {
    logic [1:0]       sel;
    logic [2:0]       n;
    logic [3:0][31:0] d;
    logic             last;
    logic [31:0]      sum;
    logic             carry;
    logic             trunc;
    logic [15:0]      beats;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm,
                     input logic [32:0] act,
                     input logic [32:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] d,
                      input logic l);
    int k = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("send_timeout", rdy, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic get(input string nm,
                     input logic [31:0] s,
                     input logic c,
                     input logic t,
                     input logic [15:0] b,
                     input int dly);
    int k = 0;
    while (!ovalid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_valid"}, ovalid, 1);
    chk({nm, "_sum"}, osum, s);
    chk({nm, "_carry"}, ocarry, c);
    chk({nm, "_trunc"}, otrunc, t);
    chk({nm, "_beats"}, obeats, b);
    repeat (dly) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic        stable;
    logic [32:0] s33;
    logic [31:0] acc;
    logic [31:0] d;
    logic        c;
    int          len;

    tbl[0] = '{2'd0, 3'd3, {32'd0, 32'd9, 32'd7, 32'd5},
               1'b1, 32'd21, 1'b0, 1'b0, 16'd3};
    tbl[1] = '{2'd0, 3'd2, {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF},
               1'b1, E_WRAP, 1'b1, 1'b0, 16'd2};
    tbl[2] = '{2'd1, 3'd4, {32'd1, 32'd1, 32'd1, 32'd1},
               1'b0, 32'd4, 1'b0, 1'b1, 16'd4};
    tbl[3] = '{2'd1, 3'd4, {32'd4, 32'd3, 32'd2, 32'd1},
               1'b1, 32'd10, 1'b0, 1'b0, 16'd4};
    tbl[4] = '{2'd2, 3'd1, {32'd0, 32'd0, 32'd0, 32'd7},
               1'b0, 32'd7, 1'b0, 1'b1, 16'd1};
    tbl[5] = '{2'd2, 3'd1, {32'd0, 32'd0, 32'd0, 32'd9},
               1'b1, 32'd9, 1'b0, 1'b0, 16'd1};
    tbl[6] = '{2'd0, 3'd1, {32'd0, 32'd0, 32'd0, 32'h01BC_0100},
               1'b1, 32'h01BC_0100, 1'b0, 1'b0, 16'd1};
    tbl[7] = '{2'd0, 3'd3,
               {32'd0, 32'd1, 32'h8000_0000, 32'h8000_0000},
               1'b1, E_WRAP, 1'b1, 1'b0, 16'd3};

    sel = 0;
    do_reset();
    chk("rst_ready", rdy, 1);
    chk("rst_valid", ovalid, 0);
    chk("rst_sum", osum, 0);
    chk("rst_carry", ocarry, 0);
    chk("rst_trunc", otrunc, 0);
    chk("rst_beats", obeats, 0);

    for (int i = 0; i < 8; i++) begin
      sel = int'(tbl[i].sel);
      do_reset();
      for (int j = 0; j < int'(tbl[i].n); j++)
        send(tbl[i].d[j],
             tbl[i].last && (j == int'(tbl[i].n) - 1));
      chk($sformatf("v%0d_latency", i), ovalid, 1);
      get($sformatf("v%0d", i), tbl[i].sum, tbl[i].carry,
          tbl[i].trunc, tbl[i].beats, 0);
    end

    // Fifth beat after forced termination opens a new packet.
    sel = 1;
    do_reset();
    repeat (4) send(32'd1, 1'b0);
    get("trunc4", 32'd4, 1'b0, 1'b1, 16'd4, 0);
    send(32'd1, 1'b1);
    get("fifth", 32'd1, 1'b0, 1'b0, 16'd1, 0);

    // Backpressure in HOLD, then release timing.
    sel = 0;
    do_reset();
    send(32'd5, 1'b1);
    in_valid = 1'b1;
    in_data = 32'd3;
    in_last = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rdy !== 1'b0 || ovalid !== 1'b1 ||
          osum !== 32'd5 || obeats !== 16'd1)
        stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    out_ready = 1'b1;
    chk("pulse_rdy", rdy, 0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_rdy", rdy, 1);
    chk("idle_valid", ovalid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    get("after_pulse", 32'd3, 1'b0, 1'b0, 16'd1, 0);

    // Reset mid-packet discards the partial sum.
    do_reset();
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    do_reset();
    chk("mid_rst_valid", ovalid, 0);
    chk("mid_rst_ready", rdy, 1);
    chk("mid_rst_sum", osum, 0);
    chk("mid_rst_beats", obeats, 0);
    send(32'd3, 1'b0);
    send(32'd4, 1'b1);
    get("post_rst", 32'd7, 1'b0, 1'b0, 16'd2, 0);

    // Reset in HOLD drops the pending result.
    send(32'd5, 1'b1);
    do_reset();
    chk("hold_rst_valid", ovalid, 0);
    chk("hold_rst_sum", osum, 0);

    // Mid-packet bubble.
    send(32'd1, 1'b0);
    repeat (3) @(negedge clk);
    chk("bubble_wait", ovalid, 0);
    send(32'd2, 1'b1);
    get("bubble", 32'd3, 1'b0, 1'b0, 16'd2, 2);

    // Random packets against a reference model.
    for (int p = 0; p < 20; p++) begin
      len = int'($urandom_range(1, 5));
      acc = '0;
      c = 1'b0;
      for (int j = 0; j < len; j++) begin
        d = (j % 2 == 1) ? {$urandom_range(0, 3), 30'd0}
                         : $urandom;
        if (j == 0) begin
          acc = d;
        end else begin
          s33 = {1'b0, acc} + {1'b0, d};
          c = c | s33[32];
          acc = (SAT && s33[32]) ? 32'hFFFF_FFFF
                                 : s33[31:0];
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(d, j == len - 1);
      end
      get($sformatf("rnd%0d", p), acc, c, 1'b0,
          16'(len), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acc32_stream.md
ACC32_STREAM -- requirements
Module: acc32_stream

Interface
REQ-001 Parameter MAX_BEATS, default 256, maximum beats per packet before forced termination (range 1..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand beat valid.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_data  input  32  unsigned operand.
REQ-007 in_last  input  1  marks final beat of the packet.
REQ-008 out_valid  output  1  packet result valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_sum  output  32  accumulated sum.
REQ-011 out_carry  output  1  sticky: at least one add in the packet produced carry-out.
REQ-012 out_trunc  output  1  packet was force-terminated at MAX_BEATS without in_last.
REQ-013 out_beats  output  16  number of beats accepted in the packet.

Function
REQ-014 States SHALL be IDLE, ACCUM and HOLD, encoded as 2 bits.
REQ-015 A beat is accepted when in_valid and in_ready are both high; in_ready is high in IDLE and ACCUM, low in HOLD.
REQ-016 Beat acceptance in IDLE: acc <= in_data, carry <= 0, beats <= 1; next state ACCUM, or HOLD if in_last.
REQ-017 Beat acceptance in ACCUM: {c, acc} <= acc + in_data (33-bit), carry <= carry | c, beats <= beats + 1; 1-cycle latency per beat.
REQ-018 ACCUM -> HOLD when the accepted beat has in_last, or when beats+1 equals MAX_BEATS (then trunc <= 1 unless in_last is also high).
REQ-019 No beat accepted: state and registers hold; in_valid low mid-packet is a legal bubble.
REQ-020 out_valid is high only in HOLD; out_sum/out_carry/out_trunc/out_beats are stable while out_valid is high.
REQ-021 HOLD with out_ready high -> IDLE next cycle; a beat presented in that cycle is not accepted (in_ready low) and is taken in IDLE the following cycle.
REQ-022 MAX_BEATS = 1: every beat goes directly IDLE -> HOLD; trunc is set when in_last is low.
REQ-023 Additions use the 32-bit carry-select adder with cin = 0; wrap-around modulo 2^32 unless the configuration below is enabled.

Reset
REQ-024 On rst: state IDLE, in_ready 1, out_valid 0, out_sum 0, out_carry 0, out_trunc 0, out_beats 0.
REQ-025 rst asserted mid-packet or in HOLD discards the partial/pending result with no output beat; rst has priority over all handshakes.

Configuration
REQ-026 Macro ACC32_STREAM_SAT_EN: when defined, any add with carry-out loads acc with 32'hFFFFFFFF and subsequent adds keep it saturated; out_carry still records the event.
REQ-027 Without ACC32_STREAM_SAT_EN, acc wraps modulo 2^32 and no saturation logic is built.

Structure
REQ-028 Shared package acc32_pkg: state enum (IDLE/ACCUM/HOLD), DATA_W = 32, BEAT_W = 16, SAT_VALUE = 32'hFFFFFFFF.
REQ-029 One sub-module: the existing carryselect_adder (32-bit, 8-bit blocks) instantiated once as the accumulator datapath; no other adder is inferred.

Verification
REQ-030 Beats 5, 7, 9 (last on 9), out_ready high -> out_valid one cycle after the last beat, out_sum 21, out_carry 0, out_beats 3, out_trunc 0.
REQ-031 Beats 32'hFFFFFFFF, 32'h00000002 (last) -> wrap build: out_sum 1, out_carry 1; SAT_EN build: out_sum 32'hFFFFFFFF, out_carry 1.
REQ-032 MAX_BEATS=4, five beats of 1 with no in_last -> result after beat 4: out_sum 4, out_beats 4, out_trunc 1; the fifth beat starts a new packet.
REQ-033 out_ready held low 10 cycles in HOLD while in_valid high -> in_ready 0, outputs stable; after out_ready pulses, next beat is accepted exactly 2 cycles after that pulse.
REQ-034 rst pulsed after 2 of 4 beats -> all outputs at reset values next cycle; new packet 3, 4 (last) gives out_sum 7, out_beats 2.
REQ-035 Single-beat packet 32'h01BC0100 with in_last, plus random bubbles on in_valid/out_ready -> out_sum 32'h01BC0100, out_beats 1; a scoreboard matches all random packets.
